// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the two handshaked buses of the fetch stage:
//     - instruction memory read channel (req/addr out, ack/rdata/err in)
//     - decode channel (valid + instruction fields out, ready in)
//   modport master : the fetch unit side
//   modport slave  : the memory / decode side (testbench, downstream stages)
// ----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_ack_i;
  logic [63:0] imem_rdata_i;
  logic        imem_err_i;

  logic        f_valid_o;
  logic        d_ready_i;
  logic [3:0]  f_icode_o;
  logic [3:0]  f_ifun_o;
  logic [3:0]  f_rA_o;
  logic [3:0]  f_rB_o;
  logic [63:0] f_valC_o;
  logic [63:0] f_valP_o;
  logic [63:0] f_predPC_o;
  logic [3:0]  f_stat_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_rdata_i, imem_err_i,
    output f_valid_o, f_icode_o, f_ifun_o, f_rA_o, f_rB_o,
    output f_valC_o, f_valP_o, f_predPC_o, f_stat_o,
    input  d_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ack_i, imem_rdata_i, imem_err_i,
    input  f_valid_o, f_icode_o, f_ifun_o, f_rA_o, f_rB_o,
    input  f_valC_o, f_valP_o, f_predPC_o, f_stat_o,
    output d_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Y86-64 fetch stage. Captures the selected PC, reads up to three aligned
//   64-bit words from instruction memory, splits the instruction into its
//   fields, computes valP / predicted PC and hands the result to decode.
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : synchronous active-low reset
//   f_pc_i   : selected fetch PC
//   flush_i  : squash the instruction in flight (highest priority)
//   bus      : fetch_unit_if.master (imem read channel + decode channel)
// ----------------------------------------------------------------------------
module fetch_unit (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [63:0]   f_pc_i,
  input  logic          flush_i,
  fetch_unit_if.master  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [3:0] ST_AOK = 4'd1;
  localparam logic [3:0] ST_HLT = 4'd2;
  localparam logic [3:0] ST_ADR = 4'd3;
  localparam logic [3:0] ST_INS = 4'd4;

  logic [2:0]  r_state;
  logic [63:0] r_pc;
  logic [1:0]  r_k;
  // Only words 0 and 1 need storage: a third word is always the last one
  // and is consumed straight off the read data in its ack cycle.
  logic [63:0] r_buf0, r_buf1;

  logic [3:0]  r_icode, r_ifun, r_ra, r_rb, r_stat;
  logic [63:0] r_valc, r_valp, r_pred;

  logic [2:0]   w_off;
  logic [63:0]  w_buf0, w_buf1;
  logic [135:0] w_line;
  logic [79:0]  w_bytes;
  logic [3:0]   w_icode, w_ifun, w_len, w_stat;
  logic         w_regs;
  logic [63:0]  w_valc, w_valp, w_pred;
  logic [5:0]   w_span, w_kend;
  logic         w_last, w_accept;

  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      4'h0, 4'h1, 4'h9:             instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:       instr_len = 4'd2;
      4'h7, 4'h8:                   instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:             instr_len = 4'd10;
      default:                      instr_len = 4'd1;
    endcase
  endfunction

  assign w_off = r_pc[2:0];

  // The word arriving this cycle overrides its (not yet written) buffer slot.
  assign w_buf0 = (r_k == 2'd0) ? bus.imem_rdata_i : r_buf0;
  assign w_buf1 = (r_k == 2'd1) ? bus.imem_rdata_i : r_buf1;
  // Highest byte ever needed is offset 7 + 9 = byte 16 of the line.
  assign w_line  = {bus.imem_rdata_i[7:0], w_buf1, w_buf0};
  assign w_bytes = w_line[{w_off, 3'b000} +: 80];

  always_comb begin
    w_icode = w_bytes[7:4];
    w_ifun  = w_bytes[3:0];
    w_len   = instr_len(w_icode);
    w_regs  = 1'b0;
    w_valc  = 64'd0;
    w_stat  = ST_AOK;
    case (w_icode)
      4'h2, 4'h6, 4'hA, 4'hB: w_regs = 1'b1;
      4'h3, 4'h4, 4'h5: begin
        w_regs = 1'b1;
        w_valc = w_bytes[79:16];
      end
      4'h7, 4'h8: w_valc = w_bytes[71:8];
      default: ;
    endcase
    if (w_icode > 4'hB)
      w_stat = ST_INS;
    else if (w_icode == 4'h0)
      w_stat = ST_HLT;
    w_valp = r_pc + {60'd0, w_len};
    w_pred = (w_icode == 4'h7 || w_icode == 4'h8) ? w_valc : w_valp;
  end

  // Done once the instruction's last byte lies within words 0..k.
  assign w_span   = {3'd0, w_off} + {2'd0, w_len};
  assign w_kend   = {({1'b0, r_k} + 3'd1), 3'b000};
  assign w_last   = (w_span <= w_kend);
  assign w_accept = (r_state == S_DONE) && bus.d_ready_i;

  always_ff @(posedge clk_i) begin
    if (r_state == S_REQ && bus.imem_ack_i) begin
      if (r_k == 2'd0) r_buf0 <= bus.imem_rdata_i;
      if (r_k == 2'd1) r_buf1 <= bus.imem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_pc    <= 64'd0;
      r_k     <= 2'd0;
      r_icode <= 4'h0;
      r_ifun  <= 4'h0;
      r_ra    <= 4'hF;
      r_rb    <= 4'hF;
      r_valc  <= 64'd0;
      r_valp  <= 64'd0;
      r_pred  <= 64'd0;
      r_stat  <= ST_AOK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!flush_i) begin
            r_pc    <= f_pc_i;
            r_k     <= 2'd0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.imem_ack_i) begin
            if (flush_i) begin
              r_state <= S_IDLE;
            end else if (bus.imem_err_i) begin
              // Bad address: deliver a NOP carrying ADR status.
              r_state <= S_DONE;
              r_icode <= 4'h1;
              r_ifun  <= 4'h0;
              r_ra    <= 4'hF;
              r_rb    <= 4'hF;
              r_valc  <= 64'd0;
              r_valp  <= r_pc + 64'd1;
              r_pred  <= r_pc + 64'd1;
              r_stat  <= ST_ADR;
            end else if (w_last) begin
              r_state <= S_DONE;
              r_icode <= w_icode;
              r_ifun  <= w_ifun;
              r_ra    <= w_regs ? w_bytes[15:12] : 4'hF;
              r_rb    <= w_regs ? w_bytes[11:8]  : 4'hF;
              r_valc  <= w_valc;
              r_valp  <= w_valp;
              r_pred  <= w_pred;
              r_stat  <= w_stat;
            end else begin
              r_k <= r_k + 2'd1;
            end
          end else if (flush_i) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.imem_ack_i) r_state <= S_IDLE;
        end
        S_DONE: begin
          if (w_accept) begin
            if (flush_i) begin
              r_state <= S_IDLE;
            end else if (r_stat == ST_AOK) begin
              r_pc    <= f_pc_i;
              r_k     <= 2'd0;
              r_state <= S_REQ;
            end else begin
              r_state <= S_HALTED;
            end
          end else if (flush_i) begin
            r_state <= S_IDLE;
          end
        end
        S_HALTED: begin
          if (flush_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req_o  = (r_state == S_REQ) || (r_state == S_DRAIN);
  assign bus.imem_addr_o = {r_pc[63:3], 3'b000} + {59'd0, r_k, 3'b000};
  assign bus.f_valid_o   = (r_state == S_DONE);
  assign bus.f_icode_o   = r_icode;
  assign bus.f_ifun_o    = r_ifun;
  assign bus.f_rA_o      = r_ra;
  assign bus.f_rB_o      = r_rb;
  assign bus.f_valC_o    = r_valc;
  assign bus.f_valP_o    = r_valp;
  assign bus.f_predPC_o  = r_pred;
  assign bus.f_stat_o    = r_stat;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Y86-64 fetch stage sitting directly downstream of PC selection: samples the selected fetch PC and reads the instruction from a 64-bit aligned, handshaked instruction memory (up to three words per instruction). It splits the instruction into fields, computes valP and the predicted next PC, and presents the result to decode through a valid/ready handshake. It stalls on memory latency or decode back-pressure, squashes on flush, and parks after delivering a non-AOK status.

## Interface
- No parameters; widths fixed by the ISA.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- f_pc_i  in  64  selected fetch PC from PC select.
- flush_i  in  1  squash current instruction; highest priority.
- imem_req_o  out  1  memory read request; held until ack.
- imem_addr_o  out  64  8-byte-aligned word address; stable while req high.
- imem_ack_i  in  1  read data valid this cycle.
- imem_rdata_i  in  64  little-endian word data.
- imem_err_i  in  1  address error; qualified by ack.
- f_valid_o  out  1  fetched instruction valid.
- d_ready_i  in  1  decode accepts when valid & ready.
- f_icode_o, f_ifun_o, f_rA_o, f_rB_o  out  4 each  instruction fields.
- f_valC_o  out  64  constant word.
- f_valP_o  out  64  PC + instruction length.
- f_predPC_o  out  64  predicted next PC.
- f_stat_o  out  4  AOK=1, HLT=2, ADR=3, INS=4.

## Operation
- States: IDLE, REQ, DRAIN, DONE, HALTED.
- IDLE: capture f_pc_i into pc_q, k=0, go REQ.
- REQ: imem_req_o=1; imem_addr_o = {pc_q[63:3],3'b0} + 8*k. On ack, store word k in a 24-byte buffer. After word 0, decode icode = high nibble of byte pc_q[2:0]. Length: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10. Words needed = ceil((pc_q[2:0]+len)/8), range 1..3. Go DONE once all words are held, else k++.
- Invalid icode (>0xB): length 1, stat INS; no further words fetched.
- imem_err_i with ack on any word: go DONE with icode=NOP(1), ifun=0, stat ADR.
- Field extraction from buffer byte offset o=pc_q[2:0]:
  - ifun = low nibble of byte o.
  - rA/rB = high/low nibble of byte o+1 for icodes 2,3,4,5,6,A,B; else 0xF.
  - valC = 8 bytes LE starting at o+2 (icodes 3,4,5) or o+1 (icodes 7,8); else 0.
- valP = pc_q + len (64-bit wrap).
- predPC = valC for JXX(7) and CALL(8), else valP.
- stat = HLT for icode 0, else AOK, unless ADR/INS applies.
- DONE: f_valid_o=1, outputs held stable.
  - On accept with stat AOK: capture f_pc_i and go REQ directly with k=0.
  - On accept with stat non-AOK: go HALTED.
- HALTED: valid=0, req=0; stays until flush or reset.
- flush_i:
  - In DONE, IDLE or HALTED: go IDLE.
  - In REQ with ack the same cycle: go IDLE.
  - In REQ without ack: go DRAIN.
- DRAIN: req held with the same address; on ack, discard data and go IDLE. A flush in DRAIN keeps DRAIN.
- Flush in the same cycle as accept: the accept completes and the instruction counts as taken. The next state is IDLE, not REQ.

## Timing
- Reset (rst_n_i low at edge): state IDLE.
  - req, valid, addr, icode, ifun, valC, valP, predPC = 0.
  - rA, rB = 0xF; stat = AOK(1).
- Minimum latency, 1-word instruction with same-cycle ack: IDLE edge, one REQ cycle, then DONE. f_valid_o high 2 cycles after IDLE entry.
- Each extra word adds 1 cycle plus memory wait.
- Back-to-back throughput with zero-wait memory: one 1-word instruction every 2 cycles (DONE, REQ).
- Only one request is outstanding at a time. Address changes only in the cycle after an ack.
- Outputs change only on entry to DONE or on reset.

## Test plan
- pc=0x0, word0 = 0x...0030_F2_..., irmovq at offset 0: 2 words fetched (addresses 0x0, 0x8); rA=F, rB=2, valC from bytes 2..9, valP=0xA, stat AOK.
- pc=0x17, irmovq at offset 7: 3 requests (0x10, 0x18, 0x20); valC assembled across words; valP=0x21.
- jmp at pc=0x40, dest 0x100: predPC=0x100, valP=0x49. Then hold d_ready_i low for 3 cycles: outputs stable, no new request.
- Byte 0xC0 at pc=0x8: stat INS, valid for one accept, then HALTED with req low. flush_i then returns to IDLE and refetches f_pc_i.
- imem_err_i with ack on word 0 at pc=0xFFF8: icode=1, stat ADR, valid high the next cycle.
- flush_i while req high with ack delayed 2 cycles: DRAIN keeps the address, data is discarded, then IDLE captures the new f_pc_i. f_valid_o never rises for the squashed PC.
